// File: rtl/icache_line_fill_server.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_fill_server
// Brief    : Fetches 4-word instruction lines for I-cache misses and keeps a
//            one-line buffer so a repeat request returns in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_fill_server #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic [63:0]       line_out,
    output logic              line_valid,
    output logic              busy,
    output logic              fill_err,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              mem_ack
);

    localparam int                c_TAG_W     = ADDR_W - 3;
    localparam int                c_WAIT_W    = 8;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DONE    = 2'd2,
        ST_HITRESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_TAG_W-1:0]  r_tag;
    logic [c_TAG_W-1:0]  r_buf_tag;
    logic [c_TAG_W-1:0]  w_req_tag;
    logic [1:0]          r_beat;
    logic [c_WAIT_W-1:0] r_wait;
    logic [3:0][15:0]    r_words;
    logic [63:0]         r_line;
    logic [63:0]         w_assembled;
    logic                r_buf_valid;
    logic                r_flush_pend;
    logic                r_fill_err;
    logic                w_hit;
    logic                w_timeout;
    logic                w_unused_addr_bits;

    assign w_req_tag          = req_addr[ADDR_W-1:3];
    assign w_unused_addr_bits = ^req_addr[2:0];
    assign w_hit              = req && !flush && r_buf_valid && (w_req_tag == r_buf_tag);
    assign w_timeout          = (r_wait == c_WAIT_LAST);
    assign w_assembled        = {r_words[0], r_words[1], r_words[2], r_words[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_next_state = ST_HITRESP;
                end else if (req) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ack && (r_beat == 2'd3)) begin
                    w_next_state = ST_DONE;
                end else if (!mem_ack && w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // r_line doubles as the buffered line: it always holds the last delivered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag        <= '0;
            r_buf_tag    <= '0;
            r_beat       <= 2'd0;
            r_wait       <= '0;
            r_words      <= '0;
            r_line       <= '0;
            r_buf_valid  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_fill_err   <= 1'b0;
        end else begin
            r_fill_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_buf_valid <= 1'b0;
                    end
                    if (req && !w_hit) begin
                        r_tag        <= w_req_tag;
                        r_beat       <= 2'd0;
                        r_wait       <= '0;
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_words[r_beat] <= mem_data;
                        r_beat          <= r_beat + 2'd1;
                        r_wait          <= '0;
                    end else if (w_timeout) begin
                        r_fill_err   <= 1'b1;
                        r_buf_valid  <= 1'b0;
                        r_flush_pend <= 1'b0;
                        r_beat       <= 2'd0;
                        r_wait       <= '0;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_line       <= w_assembled;
                    r_buf_tag    <= r_tag;
                    r_buf_valid  <= !(r_flush_pend || flush);
                    r_flush_pend <= 1'b0;
                end
                default: begin
                    if (flush) begin
                        r_buf_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign line_valid = (r_state == ST_DONE) || (r_state == ST_HITRESP);
    assign line_out   = (r_state == ST_DONE) ? w_assembled : r_line;
    assign busy       = (r_state == ST_FETCH);
    assign mem_rd     = (r_state == ST_FETCH);
    assign mem_addr   = (r_state == ST_FETCH) ? {r_tag, r_beat, 1'b0} : '0;
    assign fill_err   = r_fill_err;

endmodule
`default_nettype wire

// File: tb/tb_icache_line_fill_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_line_fill_server
// Brief    : Randomized scoreboard bench for the I-cache line fill server.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_line_fill_server;

    localparam int c_TIMEOUT = 15;
    localparam int c_STALL   = 1000;

    logic        clk;
    logic        rst;
    logic        req;
    logic [15:0] req_addr;
    logic        flush;
    logic [63:0] line_out;
    logic        line_valid;
    logic        busy;
    logic        fill_err;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ack;

    icache_line_fill_server #(.ADDR_W(16), .TIMEOUT(c_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .flush      (flush),
        .line_out   (line_out),
        .line_valid (line_valid),
        .busy       (busy),
        .fill_err   (fill_err),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [63:0] line;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t        sb_q[$];
    int          dly_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] mem [32768];

    // Reference model of the line buffer
    bit          m_valid;
    logic [12:0] m_tag;
    logic [63:0] m_line;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: per-beat ack delays come from dly_q, expected addresses from addr_q
    initial begin : responder
        int  cur;
        int  cnt;
        bit  active;
        bit  stray;
        logic [15:0] ea;
        mem_ack = 1'b0;
        mem_data = 16'h0;
        active = 1'b0;
        stray = 1'b0;
        cur = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack  = 1'b0;
            mem_data = 16'($urandom);
            if (rst || !mem_rd) begin
                active = 1'b0;
                stray  = 1'b0;
            end else begin
                if (!active && dly_q.size() == 0) begin
                    if (!stray) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_mem_rd: mem_rd=1 addr=%h, no fetch expected", mem_addr);
                    end
                    stray = 1'b1;
                end else begin
                    if (!active) begin
                        cur    = dly_q.pop_front();
                        cnt    = 0;
                        active = 1'b1;
                    end
                    if (cnt >= cur) begin
                        mem_ack  = 1'b1;
                        mem_data = mem[mem_addr[15:1]];
                        ea = (addr_q.size() != 0) ? addr_q.pop_front() : 16'hxxxx;
                        chk("mem_addr", 64'(mem_addr), 64'(ea));
                        chk("busy_in_fetch", 64'(busy), 64'(1));
                        active = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops one expected response per line_valid / fill_err pulse
    initial begin : monitor
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst && (line_valid || fill_err)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_response: line_valid=%b fill_err=%b line=%h", line_valid, fill_err, line_out);
                end else begin
                    e   = sb_q.pop_front();
                    lat = int'((longint'($time) - e.t0 - 5) / 10) + 1;
                    chk("resp_is_err", 64'(fill_err), 64'(e.is_err));
                    chk("resp_valid", 64'(line_valid), 64'(!e.is_err));
                    chk("resp_latency", 64'(lat), 64'(e.lat));
                    if (!e.is_err) begin
                        chk("line_out", line_out, e.line);
                        chk("busy_at_resp", 64'(busy), 64'(0));
                    end
                end
            end
        end
    end

    // Issue one request; the model decides hit/miss and queues expectations.
    // stall >= 0 withholds the ack of that beat so the fetch times out.
    task automatic start_req(input logic [15:0] addr, input bit flush_now, input int stall,
                             input int dly, input bit rnd, input bit flush_mid);
        logic [12:0] tag;
        logic [63:0] ln;
        bit          hit;
        exp_t        e;
        int          nb;
        int          d;
        int          sum;
        tag = addr[15:3];
        hit = m_valid && !flush_now && (tag == m_tag);
        if (flush_now) m_valid = 1'b0;
        ln  = '0;
        sum = 0;
        if (hit) begin
            e.is_err = 1'b0;
            e.line   = m_line;
            e.lat    = 1;
        end else begin
            nb = (stall >= 0) ? stall : 4;
            for (int b = 0; b < nb; b++) begin
                d = rnd ? int'($urandom_range(dly, 0)) : dly;
                dly_q.push_back(d);
                addr_q.push_back({tag, 2'(b), 1'b0});
                sum += d + 1;
            end
            for (int b = 0; b < 4; b++) ln[63-16*b -: 16] = mem[int'(tag) * 4 + b];
            if (stall >= 0) begin
                dly_q.push_back(c_STALL);
                e.is_err = 1'b1;
                e.line   = '0;
                e.lat    = sum + c_TIMEOUT + 1;
                m_valid  = 1'b0;
            end else begin
                e.is_err = 1'b0;
                e.line   = ln;
                e.lat    = sum + 1;
                m_valid  = !flush_mid;
                m_tag    = tag;
                m_line   = ln;
            end
        end
        @(negedge clk);
        req      = 1'b1;
        req_addr = addr;
        flush    = flush_now;
        @(posedge clk);
        e.t0 = longint'($time);
        sb_q.push_back(e);
        @(negedge clk);
        req      = 1'b0;
        flush    = 1'b0;
        req_addr = 16'($urandom);
        if (!hit && flush_mid) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic wait_resp();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: no response after %0d cycles, %0d pending", n, sb_q.size());
            sb_q.delete();
            dly_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic req_and_wait(input logic [15:0] addr, input bit flush_now, input int stall,
                                input int dly, input bit rnd, input bit flush_mid);
        start_req(addr, flush_now, stall, dly, rnd, flush_mid);
        wait_resp();
    endtask

    task automatic idle_flush();
        @(negedge clk);
        flush   = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag_s);
        chk({tag_s, "_line_out"}, line_out, 64'h0);
        chk({tag_s, "_line_valid"}, 64'(line_valid), 64'h0);
        chk({tag_s, "_busy"}, 64'(busy), 64'h0);
        chk({tag_s, "_fill_err"}, 64'(fill_err), 64'h0);
        chk({tag_s, "_mem_rd"}, 64'(mem_rd), 64'h0);
        chk({tag_s, "_mem_addr"}, 64'(mem_addr), 64'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int b = 0; b < 4; b++) mem[(16'h1230 >> 1) + b] = 16'hA000 + 16'(b);
        m_valid  = 1'b0;
        m_tag    = '0;
        m_line   = '0;
        rst      = 1'b1;
        req      = 1'b0;
        flush    = 1'b0;
        req_addr = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        req_and_wait(16'h1236, 1'b0, -1, 0, 1'b0, 1'b0);   // zero-wait miss
        req_and_wait(16'h1232, 1'b0, -1, 0, 1'b0, 1'b0);   // buffer hit
        req_and_wait(16'h3000, 1'b0, -1, 3, 1'b0, 1'b0);   // 3 wait states per beat
        req_and_wait(16'h4000, 1'b0,  2, 0, 1'b0, 1'b0);   // timeout on beat 2
        req_and_wait(16'h1230, 1'b0, -1, 0, 1'b0, 1'b0);   // must miss after abort
        req_and_wait(16'h2000, 1'b0, -1, 0, 1'b0, 1'b1);   // flush mid-fetch
        req_and_wait(16'h2000, 1'b0, -1, 0, 1'b0, 1'b0);   // re-fetch
        req_and_wait(16'h5000, 1'b0, -1, 1, 1'b0, 1'b0);
        req_and_wait(16'h5004, 1'b1, -1, 0, 1'b0, 1'b0);   // req+flush same cycle
        idle_flush();
        req_and_wait(16'h5002, 1'b0, -1, 0, 1'b0, 1'b0);
        req_and_wait(16'hFFF8, 1'b0, -1, 0, 1'b0, 1'b0);   // wrap
        req_and_wait(16'h0000, 1'b0, -1, 0, 1'b0, 1'b0);

        // Reset in the middle of a fetch
        req_and_wait(16'h6000, 1'b0, -1, 0, 1'b0, 1'b0);
        start_req(16'h7000, 1'b0, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb_q.delete();
        dly_q.delete();
        addr_q.delete();
        m_valid = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_valid_after_reset", 64'(line_valid), 64'h0);
        end
        req_and_wait(16'h6000, 1'b0, -1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(5, 0))
                0: a = 16'h1230;
                1: a = 16'h2000;
                2: a = 16'h8008;
                3: a = 16'hFFF8;
                4: a = 16'h0000;
                default: a = 16'h4440;
            endcase
            a = a | 16'($urandom_range(7, 0));
            if ($urandom_range(9, 0) == 0) idle_flush();
            req_and_wait(a, ($urandom_range(7, 0) == 0),
                         ($urandom_range(11, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                         3, 1'b1, ($urandom_range(7, 0) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        chk("addr_queue_drained", 64'(addr_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_line_fill_server.md
Name: icache_line_fill_server

Overview:
- Memory-side responder for the instruction cache's miss path.
- On a fill request it reads the four 16-bit instruction words of the addressed 8-byte line from a word-wide instruction memory, packs them into a 64-bit line and returns it with a one-cycle valid pulse.
- Keeps a single-line buffer of the last delivered line, so a repeat request for that line returns in one cycle.
- Sits between the instruction cache (line consumer) and the instruction memory.

Parameters:
- ADDR_W, 16, byte address width.
- TIMEOUT, 15, max cycles to wait for mem_ack on one beat before aborting; range 1..255.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  fill request; sampled only in IDLE.
- req_addr  input  16  byte address of the missing instruction; line = req_addr[15:3].
- flush  input  1  invalidate the line buffer.
- line_out  output  64  assembled line; word at offset 00 in [63:48], 01 in [47:32], 10 in [31:16], 11 in [15:0].
- line_valid  output  1  one-cycle pulse; line_out is valid this cycle.
- busy  output  1  high while a memory fetch is in progress.
- fill_err  output  1  one-cycle pulse on a timeout abort.
- mem_rd  output  1  memory read strobe.
- mem_addr  output  16  byte address of the current word, {tag, beat[1:0], 1'b0}.
- mem_data  input  16  read data; valid when mem_ack=1.
- mem_ack  input  1  beat completes at the posedge where mem_rd&&mem_ack.

Behaviour:
- Reset, applied any cycle including mid-fetch:
  - state=IDLE; outputs go to 0: line_out, line_valid, busy, fill_err, mem_rd, mem_addr.
  - buf_valid=0, buf_tag=0, beat=0, wait counter=0, flush_pend=0.
  - The in-flight fetch is discarded and no line_valid is issued.
- States: IDLE, FETCH, DONE, HITRESP.
- IDLE, req=1 and flush=0:
  - If buf_valid and req_addr[15:3]==buf_tag: go to HITRESP. Next cycle line_valid=1 and line_out = buffered line (latency 1).
  - Otherwise: latch tag=req_addr[15:3], beat=0, go to FETCH.
- IDLE, req=1 and flush=1 in the same cycle: flush first (buf_valid=0), then the request is treated as a miss.
- FETCH:
  - busy=1, mem_rd=1, mem_addr={tag,beat,1'b0}.
  - On mem_ack: store mem_data into word slot beat, clear the wait counter, beat+1. mem_rd stays high across beats.
  - After the ack for beat 3: go to DONE.
  - No ack for TIMEOUT consecutive cycles: fill_err=1 for one cycle, buf_valid=0, mem_rd=0, go to IDLE. No line_valid.
- DONE (one cycle):
  - line_valid=1, line_out=assembled line, busy=0, mem_rd=0.
  - buf_tag=tag. buf_valid=1, unless flush_pend is set, in which case buf_valid=0 and flush_pend clears.
  - Go to IDLE.
- HITRESP: one cycle with line_valid=1, then IDLE.
- Timing with mem_ack held high: req sampled at edge 0 → mem_rd high in cycles 1-4 → line_valid in cycle 5.
- req outside IDLE is ignored; the requester must hold or re-assert it.
- flush:
  - In IDLE: clears buf_valid at the next edge.
  - In FETCH: sets flush_pend. The fetched line is still delivered, but it is not retained in the buffer.
- line_out holds its value between pulses and updates only in DONE or HITRESP.
- Buffer-tag compare is a full 13-bit compare, so address wrap from 0xFFF8 to 0x0000 is handled by that compare with no special case.
- mem_addr increments only its beat field; it never carries into the tag.

Test Plan:
- Miss, zero-wait memory: req, req_addr=0x1236; memory returns words 0xA000+beat → mem_addr sequence 0x1230, 0x1232, 0x1234, 0x1236; line_valid in cycle 5; line_out=0xA000A001A002A003.
- Buffer hit: after the previous fill, req with addr=0x1232 → line_valid one cycle later, same line, mem_rd never asserted.
- Wait states plus timeout:
  - mem_ack delayed 3 cycles per beat → line_valid at cycle 17.
  - With TIMEOUT=15, ack withheld on beat 2 → fill_err pulses after 15 cycles, no line_valid, and a following req to 0x1230 misses.
- Flush during fetch: flush asserted in cycle 2 of a fill of 0x2000 → line still delivered; an immediate re-request of 0x2000 re-fetches (mem_rd high again).
- Reset mid-fetch: rst at beat 1 → next cycle all outputs 0 and busy=0; no line_valid during the next 6 cycles; buffer invalid.
- Wrap: fill 0xFFF8, then 0x0000 → two separate fetches; mem_addr reaches 0xFFFE, then restarts at 0x0000.
